// File: rtl/vx_axi_read_burst_split.sv
// AXI4 read burst splitter: cuts INCR bursts into sub-bursts bounded by MAX_BURST_LEN and
// BOUNDARY, and merges the returned R beats so upstream sees one RLAST per original burst.
module vx_axi_read_burst_split #(
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_TID_WIDTH  = 8,
   parameter int MAX_BURST_LEN  = 16,
   parameter int BOUNDARY       = 4096,
   parameter int MAX_PENDING    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [AXI_TID_WIDTH-1:0]  s_axi_arid,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic [1:0]                s_axi_arlock,
   input  logic [3:0]                s_axi_arcache,
   input  logic [2:0]                s_axi_arprot,
   input  logic [3:0]                s_axi_arqos,
   input  logic [3:0]                s_axi_arregion,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [AXI_TID_WIDTH-1:0]  s_axi_rid,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [AXI_TID_WIDTH-1:0]  m_axi_arid,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic [1:0]                m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic [3:0]                m_axi_arregion,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [AXI_TID_WIDTH-1:0]  m_axi_rid,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast
);
   localparam int BW = $clog2(BOUNDARY);
   localparam int PW = $clog2(MAX_PENDING);
   localparam int CW = (BW + 1 > 9) ? BW + 1 : 9;
   localparam logic [BW:0]    BOUND_V = BOUNDARY[BW:0];
   localparam logic [CW-1:0]  MAXL    = CW'(MAX_BURST_LEN);
   localparam logic [PW:0]    FULL_V  = MAX_PENDING[PW:0];
   localparam logic [1:0]     BURST_INCR = 2'b01;

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t                    state;
   logic [8:0]                rem;
   logic [AXI_TID_WIDTH-1:0]  cur_id;
   logic [AXI_ADDR_WIDTH-1:0] addr;
   logic [2:0]                size;
   logic [1:0]                burst;
   logic [1:0]                lock;
   logic [3:0]                cache;
   logic [2:0]                prot;
   logic [3:0]                qos;
   logic [3:0]                region;
   logic [MAX_PENDING-1:0]    fifo_final;
   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic [PW:0]               count;

   logic [AXI_ADDR_WIDTH-1:0] aligned;
   logic [AXI_ADDR_WIDTH-1:0] next_addr;
   logic [BW:0]               to_bnd;
   logic [8:0]                sub;
   logic                      is_final;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic                      ar_hs;
   logic                      m_hs;
   logic                      pop;

   // Smallest of remaining beats, the length cap and the beats left before the boundary.
   function automatic logic [8:0] min_len(input logic [8:0] r, input logic [BW:0] tb);
      logic [CW-1:0] m;
      m = CW'(r);
      if (MAXL < m) m = MAXL;
      if (CW'(tb) < m) m = CW'(tb);
      return m[8:0];
   endfunction

   assign aligned    = addr & ~((AXI_ADDR_WIDTH'(1) << size) - AXI_ADDR_WIDTH'(1));
   assign to_bnd     = (BOUND_V - {1'b0, aligned[BW-1:0]}) >> size;
   assign sub        = (burst == BURST_INCR) ? min_len(rem, to_bnd) : rem;
   assign is_final   = (rem == sub);
   assign next_addr  = aligned + (AXI_ADDR_WIDTH'(sub) << size);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_V);

   // Only same-ID bursts may overlap, which keeps R data in request order.
   assign s_axi_arready = reset && (state == IDLE) && (fifo_empty || (s_axi_arid == cur_id));
   assign ar_hs         = s_axi_arvalid && s_axi_arready;
   assign m_axi_arvalid = (state == SPLIT) && !fifo_full;
   assign m_hs          = m_axi_arvalid && m_axi_arready;

   assign m_axi_araddr   = addr;
   assign m_axi_arid     = cur_id;
   assign m_axi_arlen    = 8'(sub - 9'd1);
   assign m_axi_arsize   = size;
   assign m_axi_arburst  = burst;
   assign m_axi_arlock   = lock;
   assign m_axi_arcache  = cache;
   assign m_axi_arprot   = prot;
   assign m_axi_arqos    = qos;
   assign m_axi_arregion = region;

   assign s_axi_rvalid = m_axi_rvalid;
   assign m_axi_rready = s_axi_rready;
   assign s_axi_rdata  = m_axi_rdata;
   assign s_axi_rid    = m_axi_rid;
   assign s_axi_rresp  = m_axi_rresp;
   assign s_axi_rlast  = m_axi_rlast && (fifo_empty || fifo_final[rd_ptr]);
   assign pop          = m_axi_rvalid && s_axi_rready && m_axi_rlast && !fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rem    <= '0;
         cur_id <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  rem    <= {1'b0, s_axi_arlen} + 9'd1;
                  cur_id <= s_axi_arid;
                  state  <= SPLIT;
               end
            end
            SPLIT: begin
               if (m_hs) begin
                  rem <= rem - sub;
                  if (is_final) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (m_hs) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({m_hs, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ar_hs) begin
         addr   <= s_axi_araddr;
         size   <= s_axi_arsize;
         burst  <= s_axi_arburst;
         lock   <= s_axi_arlock;
         cache  <= s_axi_arcache;
         prot   <= s_axi_arprot;
         qos    <= s_axi_arqos;
         region <= s_axi_arregion;
      end else if (m_hs) begin
         addr <= next_addr;
      end
      if (m_hs) fifo_final[wr_ptr] <= is_final;
   end

   r_beat_without_request: assert property (@(posedge clk) disable iff (!reset)
      !(m_axi_rvalid && s_axi_rready && fifo_empty));

endmodule

// File: tb/tb_vx_axi_read_burst_split.sv
// Directed bench for vx_axi_read_burst_split: splitting, RLAST merging, ID gating,
// tracking-FIFO backpressure and reset in the middle of a split.
module tb_vx_axi_read_burst_split;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s_axi_arvalid = 1'b0;
   logic          s_axi_arready;
   logic [AW-1:0] s_axi_araddr = '0;
   logic [IW-1:0] s_axi_arid = '0;
   logic [7:0]    s_axi_arlen = '0;
   logic [2:0]    s_axi_arsize = '0;
   logic [1:0]    s_axi_arburst = 2'b01;
   logic [1:0]    s_axi_arlock = '0;
   logic [3:0]    s_axi_arcache = '0;
   logic [2:0]    s_axi_arprot = '0;
   logic [3:0]    s_axi_arqos = '0;
   logic [3:0]    s_axi_arregion = '0;
   logic          s_axi_rvalid;
   logic          s_axi_rready = 1'b1;
   logic [DW-1:0] s_axi_rdata;
   logic [IW-1:0] s_axi_rid;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast;
   logic          m_axi_arvalid;
   logic          m_axi_arready = 1'b1;
   logic [AW-1:0] m_axi_araddr;
   logic [IW-1:0] m_axi_arid;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic [1:0]    m_axi_arlock;
   logic [3:0]    m_axi_arcache;
   logic [2:0]    m_axi_arprot;
   logic [3:0]    m_axi_arqos;
   logic [3:0]    m_axi_arregion;
   logic          m_axi_rvalid = 1'b0;
   logic          m_axi_rready;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [IW-1:0] m_axi_rid = '0;
   logic [1:0]    m_axi_rresp = '0;
   logic          m_axi_rlast = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vx_axi_read_burst_split #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(IW),
      .MAX_BURST_LEN(16), .BOUNDARY(4096), .MAX_PENDING(4)
   ) dut (
      .clk(clk), .reset(reset),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
      .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
      .s_axi_arregion(s_axi_arregion),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arregion(m_axi_arregion),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      m_axi_rlast   = 1'b1;
      #1;
      checks++;
      if (s_axi_arready !== 1'b0 || m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready arready=%b arvalid=%b want 0 0", s_axi_arready, m_axi_arvalid);
      end
      checks++;
      if (m_axi_rready !== 1'b1 || s_axi_rlast !== 1'b1) begin
         errors++;
         $display("FAIL reset_passthru rready=%b rlast=%b want 1 1", m_axi_rready, s_axi_rlast);
      end
      tick();
      s_axi_arvalid = 1'b0;
      m_axi_rlast   = 1'b0;
      reset         = 1'b1;
      #1;
      checks++;
      if (s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_arready got %b want 1", s_axi_arready);
      end
   endtask

   task automatic test_single();
      s_axi_araddr = 32'h1000; s_axi_arsize = 3'd6; s_axi_arlen = 8'd3; s_axi_arid = 8'd2;
      s_axi_arburst = 2'b01; s_axi_arcache = 4'h3; s_axi_arprot = 3'h2; s_axi_arqos = 4'h5;
      s_axi_arlock = 2'b01; s_axi_arregion = 4'h9; s_axi_arvalid = 1'b1;
      #1;
      checks++;
      if (s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL single_arready got %b want 1", s_axi_arready);
      end
      tick();
      s_axi_arvalid = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1000 || m_axi_arlen !== 8'd3 || m_axi_arid !== 8'd2) begin
         errors++;
         $display("FAIL single_ar got v=%b a=%h l=%0d id=%0d want 1 1000 3 2",
                  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid);
      end
      checks++;
      if (m_axi_arsize !== 3'd6 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'h3 || m_axi_arprot !== 3'h2 ||
          m_axi_arqos !== 4'h5 || m_axi_arlock !== 2'b01 || m_axi_arregion !== 4'h9) begin
         errors++;
         $display("FAIL single_sideband got sz=%0d b=%0d c=%h p=%h q=%h l=%h r=%h want 6 1 3 2 5 1 9",
                  m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arlock, m_axi_arregion);
      end
      tick();
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_ar_done arvalid=%b want 0", m_axi_arvalid);
      end
      for (int i = 0; i < 4; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = (i == 3); m_axi_rdata = 64'(i + 32'hA0);
         m_axi_rid = 8'd2; m_axi_rresp = 2'b01;
         #1;
         checks++;
         if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== (i == 3) || s_axi_rdata !== 64'(i + 32'hA0) ||
             s_axi_rid !== 8'd2 || s_axi_rresp !== 2'b01) begin
            errors++;
            $display("FAIL single_r beat %0d got v=%b last=%b d=%h id=%0d resp=%0d want 1 %b %h 2 1",
                     i, s_axi_rvalid, s_axi_rlast, s_axi_rdata, s_axi_rid, s_axi_rresp, (i == 3), i + 32'hA0);
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
   endtask

   task automatic test_length_split();
      s_axi_araddr = 32'h0; s_axi_arsize = 3'd6; s_axi_arlen = 8'd63; s_axi_arid = 8'd4;
      s_axi_arvalid = 1'b1;
      #1;
      tick();
      s_axi_arvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'(k * 32'h400) || m_axi_arlen !== 8'd15 || m_axi_arid !== 8'd4) begin
            errors++;
            $display("FAIL length_ar %0d got v=%b a=%h l=%0d id=%0d want 1 %h 15 4",
                     k, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid, k * 32'h400);
         end
         tick();
      end
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL length_ar_done arvalid=%b want 0", m_axi_arvalid);
      end
      for (int i = 0; i < 64; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = ((i % 16) == 15); m_axi_rid = 8'd4; m_axi_rdata = 64'(i);
         #1;
         checks++;
         if (s_axi_rlast !== (i == 63)) begin
            errors++;
            $display("FAIL length_rlast beat %0d got %b want %b", i, s_axi_rlast, (i == 63));
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
   endtask

   task automatic test_boundary();
      s_axi_araddr = 32'hF80; s_axi_arsize = 3'd6; s_axi_arlen = 8'd7; s_axi_arid = 8'd1;
      s_axi_arvalid = 1'b1;
      #1;
      tick();
      s_axi_arvalid = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'hF80 || m_axi_arlen !== 8'd1) begin
         errors++;
         $display("FAIL boundary_ar0 got v=%b a=%h l=%0d want 1 f80 1", m_axi_arvalid, m_axi_araddr, m_axi_arlen);
      end
      tick();
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1000 || m_axi_arlen !== 8'd5) begin
         errors++;
         $display("FAIL boundary_ar1 got v=%b a=%h l=%0d want 1 1000 5", m_axi_arvalid, m_axi_araddr, m_axi_arlen);
      end
      tick();
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL boundary_ar_done arvalid=%b want 0", m_axi_arvalid);
      end
      for (int i = 0; i < 8; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = (i == 1) || (i == 7); m_axi_rid = 8'd1;
         #1;
         checks++;
         if (s_axi_rlast !== (i == 7)) begin
            errors++;
            $display("FAIL boundary_rlast beat %0d got %b want %b", i, s_axi_rlast, (i == 7));
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
   endtask

   task automatic test_id_gating();
      s_axi_araddr = 32'h0; s_axi_arsize = 3'd6; s_axi_arlen = 8'd17; s_axi_arid = 8'd3;
      s_axi_arvalid = 1'b1;
      #1;
      tick();
      s_axi_arvalid = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'd15) begin
         errors++;
         $display("FAIL gating_ar0 got v=%b a=%h l=%0d want 1 0 15", m_axi_arvalid, m_axi_araddr, m_axi_arlen);
      end
      tick();
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h400 || m_axi_arlen !== 8'd1) begin
         errors++;
         $display("FAIL gating_ar1 got v=%b a=%h l=%0d want 1 400 1", m_axi_arvalid, m_axi_araddr, m_axi_arlen);
      end
      tick();
      s_axi_arid = 8'd5;
      #1;
      checks++;
      if (s_axi_arready !== 1'b0) begin
         errors++;
         $display("FAIL gating_other_id arready=%b want 0", s_axi_arready);
      end
      s_axi_arid = 8'd3; s_axi_araddr = 32'h2000; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
      #1;
      checks++;
      if (s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL gating_same_id arready=%b want 1", s_axi_arready);
      end
      tick();
      s_axi_arvalid = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h2000 || m_axi_arlen !== 8'd0 || m_axi_arid !== 8'd3) begin
         errors++;
         $display("FAIL gating_ar2 got v=%b a=%h l=%0d id=%0d want 1 2000 0 3",
                  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid);
      end
      tick();
      s_axi_arid = 8'd5;
      for (int i = 0; i < 18; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = (i == 15) || (i == 17); m_axi_rid = 8'd3;
         #1;
         checks++;
         if (s_axi_rlast !== (i == 17) || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL gating_r beat %0d got rlast=%b arready=%b want %b 0", i, s_axi_rlast, s_axi_arready, (i == 17));
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      #1;
      checks++;
      if (s_axi_arready !== 1'b0) begin
         errors++;
         $display("FAIL gating_still_pending arready=%b want 0", s_axi_arready);
      end
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
      #1;
      checks++;
      if (s_axi_rlast !== 1'b1) begin
         errors++;
         $display("FAIL gating_last_rlast got %b want 1", s_axi_rlast);
      end
      tick();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      #1;
      checks++;
      if (s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL gating_released arready=%b want 1", s_axi_arready);
      end
   endtask

   task automatic test_backpressure();
      s_axi_araddr = 32'h0; s_axi_arsize = 3'd6; s_axi_arlen = 8'd127; s_axi_arid = 8'd1;
      s_axi_arvalid = 1'b1;
      #1;
      tick();
      s_axi_arvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'(k * 32'h400)) begin
            errors++;
            $display("FAIL bp_ar %0d got v=%b a=%h want 1 %h", k, m_axi_arvalid, m_axi_araddr, k * 32'h400);
         end
         tick();
      end
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0 || m_axi_araddr !== 32'h1000) begin
         errors++;
         $display("FAIL bp_full got v=%b a=%h want 0 1000", m_axi_arvalid, m_axi_araddr);
      end
      for (int i = 0; i < 16; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = (i == 15); m_axi_rid = 8'd1;
         #1;
         checks++;
         if (m_axi_arvalid !== 1'b0 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold beat %0d got arvalid=%b rlast=%b want 0 0", i, m_axi_arvalid, s_axi_rlast);
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1000) begin
         errors++;
         $display("FAIL bp_resume got v=%b a=%h want 1 1000", m_axi_arvalid, m_axi_araddr);
      end
      for (int i = 0; i < 16; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = (i == 15); m_axi_arready = (i == 15);
         #1;
         checks++;
         if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1000) begin
            errors++;
            $display("FAIL bp_stall beat %0d got v=%b a=%h want 1 1000", i, m_axi_arvalid, m_axi_araddr);
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b1;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1400) begin
         errors++;
         $display("FAIL bp_push_pop got v=%b a=%h want 1 1400", m_axi_arvalid, m_axi_araddr);
      end
      tick();
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL bp_refull arvalid=%b want 0", m_axi_arvalid);
      end
      for (int i = 0; i < 96; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rlast = ((i % 16) == 15);
         #1;
         checks++;
         if (s_axi_rlast !== (i == 95)) begin
            errors++;
            $display("FAIL bp_drain_rlast beat %0d got %b want %b", i, s_axi_rlast, (i == 95));
         end
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      s_axi_arid = 8'd7;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL bp_done got arvalid=%b arready=%b want 0 1", m_axi_arvalid, s_axi_arready);
      end
   endtask

   task automatic test_reset_mid_split();
      s_axi_araddr = 32'h0; s_axi_arsize = 3'd6; s_axi_arlen = 8'd63; s_axi_arid = 8'd6;
      s_axi_arvalid = 1'b1;
      #1;
      tick();
      s_axi_arvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'(k * 32'h400)) begin
            errors++;
            $display("FAIL rst_mid_ar %0d got v=%b a=%h want 1 %h", k, m_axi_arvalid, m_axi_araddr, k * 32'h400);
         end
         tick();
      end
      reset = 1'b0;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_asserted got arvalid=%b arready=%b want 0 0", m_axi_arvalid, s_axi_arready);
      end
      tick();
      reset = 1'b1;
      s_axi_arid = 8'd9;
      #1;
      checks++;
      if (s_axi_arready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_released got arready=%b arvalid=%b want 1 0", s_axi_arready, m_axi_arvalid);
      end
      test_single();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_length_split();
      test_boundary();
      test_id_gating();
      test_backpressure();
      test_reset_mid_split();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
